// File: rtl/term_writer_if.sv
//------------------------------------------------------------------------------
// Module      : term_writer_if
// Description : Character input and framebuffer write bundle for term_writer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface term_writer_if;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [7:0]  write_posx;
    logic [5:0]  write_posy;
    logic [31:0] write_value;
    logic        write_enable;
    logic [5:0]  v_offset;
    logic        busy;

    // Character source and framebuffer/display consumer side
    modport master (
        output char_data, char_valid, fg_color, bg_color,
        input  char_ready, write_posx, write_posy, write_value, write_enable,
               v_offset, busy
    );

    // Terminal writer side
    modport slave (
        input  char_data, char_valid, fg_color, bg_color,
        output char_ready, write_posx, write_posy, write_value, write_enable,
               v_offset, busy
    );
endinterface

`default_nettype wire

// File: rtl/term_writer.sv
//------------------------------------------------------------------------------
// Module      : term_writer
// Description : Text terminal writer: clears the screen, then prints bytes into
//               a cell framebuffer with wrap and hardware scroll.
//               Optional control-code decode with TERM_WRITER_CTRL_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module term_writer #(
    parameter int          COLS    = 160,
    parameter int          ROWS    = 45,
    parameter logic [11:0] INIT_FG = 12'hFFF,
    parameter logic [11:0] INIT_BG = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    term_writer_if.slave  bus
);

    localparam logic [7:0] c_COLS_M1 = 8'(COLS - 1);
    localparam logic [5:0] c_ROWS_M1 = 6'(ROWS - 1);
    localparam logic [7:0] c_SPACE   = 8'h20;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cx, w_cx_nx;
    logic [5:0]  r_cy, w_cy_nx;
    logic [5:0]  r_voff, w_voff_nx;
    logic [11:0] r_fg_l, w_fg_l_nx;
    logic [11:0] r_bg_l, w_bg_l_nx;
    logic        r_we, w_we_nx;
    logic [7:0]  r_posx, w_posx_nx;
    logic [5:0]  r_posy, w_posy_nx;
    logic [31:0] r_val, w_val_nx;

    logic        w_ready;
    logic        w_xfer;
    logic        w_print;
    logic        w_lf;
    logic [6:0]  w_row_sum;
    logic [5:0]  w_phys;

    assign w_ready = (r_state == S_IDLE) && rst_n;
    assign w_xfer  = bus.char_valid && w_ready;

    // Logical row to physical framebuffer row through the scroll offset
    assign w_row_sum = {1'b0, r_cy} + {1'b0, r_voff};
    assign w_phys    = (w_row_sum >= 7'(ROWS)) ? 6'(w_row_sum - 7'(ROWS))
                                               : w_row_sum[5:0];

    always_comb begin
        w_state_nx = r_state;
        w_cx_nx    = r_cx;
        w_cy_nx    = r_cy;
        w_voff_nx  = r_voff;
        w_fg_l_nx  = r_fg_l;
        w_bg_l_nx  = r_bg_l;
        w_we_nx    = 1'b0;
        w_posx_nx  = r_posx;
        w_posy_nx  = r_posy;
        w_val_nx   = r_val;
        w_print    = 1'b0;
        w_lf       = 1'b0;

        case (r_state)
            S_INIT: begin
                w_we_nx   = 1'b1;
                w_posx_nx = r_cx;
                w_posy_nx = w_phys;
                w_val_nx  = {INIT_FG, INIT_BG, c_SPACE};
                if (r_cx == c_COLS_M1) begin
                    w_cx_nx = 8'd0;
                    if (r_cy == c_ROWS_M1) begin
                        w_cy_nx    = 6'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cy_nx = r_cy + 6'd1;
                    end
                end else begin
                    w_cx_nx = r_cx + 8'd1;
                end
            end

            S_IDLE: begin
                if (w_xfer) begin
`ifdef TERM_WRITER_CTRL_EN
                    if (bus.char_data == 8'h0A) begin
                        w_cx_nx = 8'd0;
                        w_lf    = 1'b1;
                    end else if (bus.char_data == 8'h0D) begin
                        w_cx_nx = 8'd0;
                    end else if (bus.char_data == 8'h08) begin
                        if (r_cx != 8'd0) begin
                            w_cx_nx = r_cx - 8'd1;
                        end
                    end else begin
                        w_print = 1'b1;
                    end
`else
                    w_print = 1'b1;
`endif
                    if (w_print) begin
                        w_we_nx   = 1'b1;
                        w_posx_nx = r_cx;
                        w_posy_nx = w_phys;
                        w_val_nx  = {bus.fg_color, bus.bg_color, bus.char_data};
                        if (r_cx == c_COLS_M1) begin
                            w_cx_nx = 8'd0;
                            w_lf    = 1'b1;
                        end else begin
                            w_cx_nx = r_cx + 8'd1;
                        end
                    end

                    // Line feed on the last row scrolls instead of moving down
                    if (w_lf) begin
                        if (r_cy == c_ROWS_M1) begin
                            w_voff_nx  = (r_voff == c_ROWS_M1) ? 6'd0 : r_voff + 6'd1;
                            w_fg_l_nx  = bus.fg_color;
                            w_bg_l_nx  = bus.bg_color;
                            w_state_nx = S_CLEAR;
                        end else begin
                            w_cy_nx = r_cy + 6'd1;
                        end
                    end
                end
            end

            S_CLEAR: begin
                w_we_nx   = 1'b1;
                w_posx_nx = r_cx;
                w_posy_nx = w_phys;
                w_val_nx  = {r_fg_l, r_bg_l, c_SPACE};
                if (r_cx == c_COLS_M1) begin
                    w_cx_nx    = 8'd0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cx_nx = r_cx + 8'd1;
                end
            end

            default: begin
                w_state_nx = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_cx    <= 8'd0;
            r_cy    <= 6'd0;
            r_voff  <= 6'd0;
            r_fg_l  <= 12'd0;
            r_bg_l  <= 12'd0;
            r_we    <= 1'b0;
            r_posx  <= 8'd0;
            r_posy  <= 6'd0;
            r_val   <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_cx    <= w_cx_nx;
            r_cy    <= w_cy_nx;
            r_voff  <= w_voff_nx;
            r_fg_l  <= w_fg_l_nx;
            r_bg_l  <= w_bg_l_nx;
            r_we    <= w_we_nx;
            r_posx  <= w_posx_nx;
            r_posy  <= w_posy_nx;
            r_val   <= w_val_nx;
        end
    end

    assign bus.char_ready   = w_ready;
    assign bus.busy         = ~w_ready;
    assign bus.write_posx   = r_posx;
    assign bus.write_posy   = r_posy;
    assign bus.write_value  = r_val;
    assign bus.write_enable = r_we;
    assign bus.v_offset     = r_voff;

endmodule

`default_nettype wire
